// File: rtl/booth_mul_seq_pkg.sv
// booth_mul_seq_pkg: shared types, Booth triplet constants and helpers for the radix-4 Booth multiplier
//   state_t     : FSM states IDLE/RUN/DONE
//   TRIP_*      : 3-bit Booth triplets {q[2i+1], q[2i], q[2i-1]}
//   digit_t     : recoded digit as sign + magnitude {0,1,2}
//   num_digits  : Booth digits needed for a WIDTH-bit operand extended to WIDTH+2 bits
package booth_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam logic [2:0] TRIP_P1A = 3'b001;
   localparam logic [2:0] TRIP_P1B = 3'b010;
   localparam logic [2:0] TRIP_P2  = 3'b011;
   localparam logic [2:0] TRIP_M2  = 3'b100;
   localparam logic [2:0] TRIP_M1A = 3'b101;
   localparam logic [2:0] TRIP_M1B = 3'b110;
   typedef struct packed {
      logic       neg;
      logic [1:0] mag;
   } digit_t;
   function automatic int num_digits(input int width);
      return width / 2 + 1;
   endfunction
   function automatic digit_t recode(input logic [2:0] t);
      digit_t d;
      d = '{neg: 1'b0, mag: 2'd0};
      case (t)
         TRIP_P1A, TRIP_P1B: d = '{neg: 1'b0, mag: 2'd1};
         TRIP_P2:            d = '{neg: 1'b0, mag: 2'd2};
         TRIP_M2:            d = '{neg: 1'b1, mag: 2'd2};
         TRIP_M1A, TRIP_M1B: d = '{neg: 1'b1, mag: 2'd1};
         default:            d = '{neg: 1'b0, mag: 2'd0};
      endcase
      return d;
   endfunction
endpackage

// File: rtl/booth_mul_seq_if.sv
// booth_mul_seq_if: start/done handshake bundle between control unit (master) and multiplier (slave)
//   start, signed_mode, m, q : request and operands, driven by master
//   busy, done, product      : status and 2*WIDTH-bit result, driven by slave
interface booth_mul_seq_if #(parameter int WIDTH = 32);
   logic                 start;
   logic                 signed_mode;
   logic [WIDTH-1:0]     m;
   logic [WIDTH-1:0]     q;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;
   modport master (output start, signed_mode, m, q, input busy, done, product);
   modport slave  (input start, signed_mode, m, q, output busy, done, product);
endinterface

// File: rtl/booth_mul_seq_recode.sv
// booth_recode: combinational radix-4 Booth digit recoder producing a full-width partial product
//   trip_i  : Booth triplet {q[2i+1], q[2i], q[2i-1]}
//   m_ext_i : multiplicand already extended to WIDTH+2 bits
//   pp_o    : 0, +-M or +-2M sign-extended to the 2*WIDTH+4-bit accumulator width
module booth_recode import booth_pkg::*; #(
   parameter int WIDTH = 32
) (
   input  logic [2:0]         trip_i,
   input  logic [WIDTH+1:0]   m_ext_i,
   output logic [2*WIDTH+3:0] pp_o
);
   digit_t               d;
   logic [2*WIDTH+3:0]   m_full;
   logic [2*WIDTH+3:0]   mag_v;
   always_comb begin
      d      = recode(trip_i);
      m_full = {{(WIDTH+2){m_ext_i[WIDTH+1]}}, m_ext_i};
      mag_v  = d.mag == 2'd2 ? m_full << 1 : d.mag == 2'd1 ? m_full : '0;
      pp_o   = d.neg ? ~mag_v + 1'b1 : mag_v;
   end
endmodule

// File: rtl/booth_mul_seq.sv
// booth_mul_seq: iterative radix-4 Booth multiplier, one digit per clock, signed or unsigned
//   clk : clock, rising edge
//   clr : synchronous active-high clear, beats start
//   bus : slave side of booth_mul_seq_if (start/operands in, busy/done/product out)
module booth_mul_seq import booth_pkg::*; #(
   parameter int WIDTH = 32
) (
   input  logic           clk,
   input  logic           clr,
   booth_mul_seq_if.slave bus
);
   localparam int N  = num_digits(WIDTH);
   localparam int CW = $clog2(N);
   localparam int AW = 2 * WIDTH + 4;
   state_t               state_q;
   logic [CW-1:0]        cnt_q;
   logic [WIDTH+1:0]     m_ext_q;
   logic [WIDTH+2:0]     q_sh_q;
   logic [AW-1:0]        acc_q;
   logic [AW-1:0]        acc_d;
   logic [AW-1:0]        pp;
   logic                 busy_q;
   logic                 done_q;
   logic [2*WIDTH-1:0]   product_q;
   logic [WIDTH+1:0]     m_ext_d;
   logic [WIDTH+1:0]     q_ext_d;
   logic                 accept;
   always_comb begin
      m_ext_d = {{2{bus.signed_mode & bus.m[WIDTH-1]}}, bus.m};
      q_ext_d = {{2{bus.signed_mode & bus.q[WIDTH-1]}}, bus.q};
      accept  = bus.start & (state_q != RUN);
      // digit i carries weight 4^i, so shift the partial product by 2*cnt
      acc_d   = acc_q + (pp << {cnt_q, 1'b0});
   end
   // q_sh_q holds {q_ext, q[-1]=0}; its low three bits are always the current triplet
   booth_recode #(.WIDTH(WIDTH)) u_recode (
      .trip_i  (q_sh_q[2:0]),
      .m_ext_i (m_ext_q),
      .pp_o    (pp)
   );
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         m_ext_q   <= '0;
         q_sh_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         product_q <= '0;
      end else if (accept) begin
         state_q   <= RUN;
         cnt_q     <= '0;
         acc_q     <= '0;
         m_ext_q   <= m_ext_d;
         q_sh_q    <= {q_ext_d, 1'b0};
         busy_q    <= 1'b1;
         done_q    <= 1'b0;
         product_q <= '0;
      end else if (state_q == RUN) begin
         acc_q  <= acc_d;
         cnt_q  <= cnt_q + 1'b1;
         q_sh_q <= q_sh_q >> 2;
         if (cnt_q == CW'(N - 1)) begin
            state_q   <= DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            product_q <= acc_d[2*WIDTH-1:0];
         end
      end else begin
         state_q <= IDLE;
         done_q  <= 1'b0;
      end
   end
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.product = product_q;
endmodule
